// File: rtl/jtag_tap_master.sv
// Purpose : command-driven JTAG host; turns RESET/SHIFT_IR/SHIFT_DR/IDLE commands into TMS/TDI on a divided TCK and returns captured TDO.
// Latency : first TMS/TDI one cycle after accept; rsp_valid after (pre+len+post) TCK periods of 2*TCK_DIV cycles, or one cycle for zero-length shifts.
// Backpressure: single outstanding command; cmd_ready low from the cycle after accept until the cycle after rsp_valid; rsp has no ready.
//
// Ports:
//   system_clk, reset_bar         clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake; cmd_op/cmd_len/cmd_data latched on accept
//   rsp_valid/rsp_data            one-cycle completion pulse, TDO bits right-aligned (held until next completion)
//   TCK/TMS/TDI/TDO               JTAG pins toward the TAP controller
// Optional (define JTAG_TAP_MASTER_STATE_TRACK_EN):
//   tap_state[3:0]                shadow of the TAP state (Reset=0 .. Update_IR=15)
//   tap_state_err                 one-cycle pulse when a shift is accepted outside Run-Idle
module jtag_tap_master #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 6,
  parameter int TCK_DIV = 4
) (
  input  logic              system_clk,
  input  logic              reset_bar,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
`ifdef JTAG_TAP_MASTER_STATE_TRACK_EN
  ,
  output logic [3:0]        tap_state,
  output logic              tap_state_err
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_IDLE  = 2'b11;

  localparam int               DIV_W    = $clog2(2 * TCK_DIV);
  localparam logic [DIV_W-1:0] DIV_TOP  = DIV_W'(2 * TCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HI   = DIV_W'(TCK_DIV);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_W);

  // Number of TMS bits in the preamble for each op.
  function automatic logic [LEN_W-1:0] pre_len(input logic [1:0] op);
    case (op)
      OP_RESET: pre_len = LEN_W'(6);
      OP_IR:    pre_len = LEN_W'(4);
      default:  pre_len = LEN_W'(3);
    endcase
  endfunction

  // Preamble patterns are a run of ones followed by zeros; this is the run length.
  function automatic logic [LEN_W-1:0] pre_ones(input logic [1:0] op);
    case (op)
      OP_RESET: pre_ones = LEN_W'(5);
      OP_IR:    pre_ones = LEN_W'(2);
      default:  pre_ones = LEN_W'(1);
    endcase
  endfunction

  logic [2:0]        state, nxt_state;
  logic [1:0]        op_q, nxt_op;
  logic [LEN_W-1:0]  len_q, nxt_len, len_clamp;
  logic [LEN_W-1:0]  cnt, nxt_cnt, cnt_inc;
  logic [DATA_W-1:0] dat_q, nxt_dat;
  logic [DATA_W-1:0] cap_q, cap_bit;
  logic [DIV_W-1:0]  div;
  logic              nxt_tms, nxt_tdi;
  logic              active, accept, wrap, rise, step;

  assign active    = (state == S_PRE) || (state == S_SHIFT) || (state == S_POST);
  assign accept    = cmd_valid && cmd_ready;
  assign wrap      = active && (div == DIV_TOP);   // TCK falling edge: next TMS/TDI
  assign rise      = active && (div == DIV_RISE);  // TCK rising edge: sample TDO
  assign step      = accept || wrap;
  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign TCK       = active && (div >= DIV_HI);
  assign len_clamp = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  assign cnt_inc   = cnt + LEN_W'(1);
  assign cap_bit   = {{(DATA_W-1){1'b0}}, TDO};

  // Next bit position, then the TMS/TDI value for the TCK period it starts.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_dat   = dat_q;
    if (accept) begin
      nxt_cnt = '0;
      nxt_dat = cmd_data;
      if (cmd_op == OP_RESET)     nxt_state = S_PRE;
      else if (len_clamp == '0)   nxt_state = S_DONE;
      else if (cmd_op == OP_IDLE) nxt_state = S_SHIFT;
      else                        nxt_state = S_PRE;
    end else if (wrap) begin
      case (state)
        S_PRE: begin
          if (cnt_inc < pre_len(op_q)) begin
            nxt_cnt = cnt_inc;
          end else begin
            nxt_cnt   = '0;
            nxt_state = (op_q == OP_RESET) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt_inc < len_q) begin
            nxt_cnt = cnt_inc;
            nxt_dat = dat_q >> 1;
          end else begin
            nxt_cnt   = '0;
            nxt_state = (op_q == OP_IDLE) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (cnt == '0) begin
            nxt_cnt = cnt_inc;
          end else begin
            nxt_cnt   = '0;
            nxt_state = S_DONE;
          end
        end
        default: ;
      endcase
    end

    nxt_op  = accept ? cmd_op : op_q;
    nxt_len = accept ? len_clamp : len_q;
    nxt_tms = 1'b0;
    nxt_tdi = 1'b1;
    case (nxt_state)
      S_PRE:   nxt_tms = (nxt_cnt < pre_ones(nxt_op));
      S_SHIFT: begin
        if (nxt_op != OP_IDLE) begin
          nxt_tdi = nxt_dat[0];
          nxt_tms = (nxt_cnt == nxt_len - LEN_W'(1));  // last bit moves to Exit1
        end
      end
      S_POST:  nxt_tms = (nxt_cnt == '0);              // Update, then Run-Idle
      default: ;
    endcase
  end

  always_ff @(posedge system_clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state    <= S_IDLE;
      op_q     <= OP_RESET;
      len_q    <= '0;
      cnt      <= '0;
      dat_q    <= '0;
      cap_q    <= '0;
      div      <= '0;
      TMS      <= 1'b1;
      TDI      <= 1'b1;
      rsp_data <= '0;
    end else begin
      div <= active ? ((div == DIV_TOP) ? '0 : div + DIV_W'(1)) : '0;

      if (state == S_DONE) begin
        state <= S_IDLE;
      end else if (step) begin
        state <= nxt_state;
        cnt   <= nxt_cnt;
        dat_q <= nxt_dat;
        TMS   <= nxt_tms;
        TDI   <= nxt_tdi;
      end

      // TDO enters at the top of a len-wide window so the first bit lands at bit 0.
      if (accept) begin
        op_q  <= cmd_op;
        len_q <= len_clamp;
        cap_q <= '0;
      end else if (rise && (state == S_SHIFT) && (op_q != OP_IDLE)) begin
        cap_q <= (cap_q >> 1) | (cap_bit << (len_q - LEN_W'(1)));
      end

      if (step && (nxt_state == S_DONE)) begin
        rsp_data <= accept ? '0 : cap_q;
      end
    end
  end

`ifdef JTAG_TAP_MASTER_STATE_TRACK_EN
  function automatic logic [3:0] tap_next(input logic [3:0] st, input logic tms);
    case (st)
      4'd0:    tap_next = tms ? 4'd0  : 4'd1;
      4'd1:    tap_next = tms ? 4'd2  : 4'd1;
      4'd2:    tap_next = tms ? 4'd9  : 4'd3;
      4'd3:    tap_next = tms ? 4'd5  : 4'd4;
      4'd4:    tap_next = tms ? 4'd5  : 4'd4;
      4'd5:    tap_next = tms ? 4'd8  : 4'd6;
      4'd6:    tap_next = tms ? 4'd7  : 4'd6;
      4'd7:    tap_next = tms ? 4'd8  : 4'd4;
      4'd8:    tap_next = tms ? 4'd2  : 4'd1;
      4'd9:    tap_next = tms ? 4'd0  : 4'd10;
      4'd10:   tap_next = tms ? 4'd12 : 4'd11;
      4'd11:   tap_next = tms ? 4'd12 : 4'd11;
      4'd12:   tap_next = tms ? 4'd15 : 4'd13;
      4'd13:   tap_next = tms ? 4'd14 : 4'd13;
      4'd14:   tap_next = tms ? 4'd15 : 4'd11;
      default: tap_next = tms ? 4'd2  : 4'd1;
    endcase
  endfunction

  always_ff @(posedge system_clk or negedge reset_bar) begin
    if (!reset_bar) begin
      tap_state     <= 4'd0;
      tap_state_err <= 1'b0;
    end else begin
      if (rise) tap_state <= tap_next(tap_state, TMS);
      tap_state_err <= accept && ((cmd_op == OP_IR) || (cmd_op == OP_DR)) && (tap_state != 4'd1);
    end
  end
`endif

endmodule

// File: tb/tb_jtag_tap_master.sv
// Bench for jtag_tap_master: directed commands against a small TAP model,
// expected responses queued at issue time and checked by a separate monitor.
module tb_jtag_tap_master;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 6;
  localparam int TCK_DIV = 2;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_IDLE  = 2'b11;

  logic              system_clk = 1'b0;
  logic              reset_bar  = 1'b0;
  logic              cmd_valid  = 1'b0;
  logic [1:0]        cmd_op     = 2'b00;
  logic [LEN_W-1:0]  cmd_len    = '0;
  logic [DATA_W-1:0] cmd_data   = '0;
  logic              TDO        = 1'b0;
  logic              cmd_ready, rsp_valid, TCK, TMS, TDI;
  logic [DATA_W-1:0] rsp_data;

  jtag_tap_master #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TCK_DIV(TCK_DIV)) dut (
    .system_clk(system_clk), .reset_bar(reset_bar),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 system_clk = ~system_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rsp_cyc = 0;
  int rsp_cnt = 0;

  always @(posedge system_clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: expected responses pushed at issue, popped on rsp_valid.
  logic [DATA_W-1:0] exp_q[$];
  string             name_q[$];

  always @(posedge system_clk) begin
    #1;
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_data 0x%0h with no command pending", rsp_data);
      end else begin
        check({name_q.pop_front(), "_rsp_data"}, 64'(rsp_data), 64'(exp_q.pop_front()));
      end
    end
  end

  // Pin log: TMS/TDI as seen by the TAP on each TCK rising edge.
  logic tms_log[$];
  logic tdi_log[$];
  always @(posedge TCK) begin
    tms_log.push_back(TMS);
    tdi_log.push_back(TDI);
  end

  function automatic logic [63:0] log_bits(input bit sel_tdi, input int from, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      if (from + i < tms_log.size()) v[i] = sel_tdi ? tdi_log[from+i] : tms_log[from+i];
    return v;
  endfunction

  // TAP model: 3-bit IR capturing 3'b101, DR is a 1-bit bypass capturing 0.
  function automatic logic [3:0] tap_nxt(input logic [3:0] st, input logic tms);
    case (st)
      4'd0:    return tms ? 4'd0  : 4'd1;
      4'd1:    return tms ? 4'd2  : 4'd1;
      4'd2:    return tms ? 4'd9  : 4'd3;
      4'd3:    return tms ? 4'd5  : 4'd4;
      4'd4:    return tms ? 4'd5  : 4'd4;
      4'd5:    return tms ? 4'd8  : 4'd6;
      4'd6:    return tms ? 4'd7  : 4'd6;
      4'd7:    return tms ? 4'd8  : 4'd4;
      4'd8:    return tms ? 4'd2  : 4'd1;
      4'd9:    return tms ? 4'd0  : 4'd10;
      4'd10:   return tms ? 4'd12 : 4'd11;
      4'd11:   return tms ? 4'd12 : 4'd11;
      4'd12:   return tms ? 4'd15 : 4'd13;
      4'd13:   return tms ? 4'd14 : 4'd13;
      4'd14:   return tms ? 4'd15 : 4'd11;
      default: return tms ? 4'd2  : 4'd1;
    endcase
  endfunction

  logic [3:0] tap_st = 4'd0;
  logic [2:0] ir     = 3'b000;
  logic [2:0] ir_sr  = 3'b000;
  logic       byp    = 1'b0;

  always @(posedge TCK) begin
    case (tap_st)
      4'd3:    byp = 1'b0;
      4'd4:    byp = TDI;
      4'd10:   ir_sr = 3'b101;
      4'd11:   ir_sr = {TDI, ir_sr[2:1]};
      4'd15:   ir = ir_sr;
      default: ;
    endcase
    tap_st = tap_nxt(tap_st, TMS);
  end

  always @(negedge TCK)
    TDO = (tap_st == 4'd11) ? ir_sr[0] : ((tap_st == 4'd4) ? byp : 1'b0);

  task automatic wait_ready(input string nm);
    int k;
    k = 0;
    while (!cmd_ready && k < 2000) begin @(negedge system_clk); k++; end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: cmd_ready %0b expected 1", nm, cmd_ready);
    end
  endtask

  task automatic issue(input logic [1:0] op, input int len, input logic [DATA_W-1:0] data,
                       input logic [DATA_W-1:0] exp, input bit expect_rsp, input string nm);
    wait_ready(nm);
    @(negedge system_clk);
    tms_log.delete();
    tdi_log.delete();
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    cmd_data  = data;
    cmd_valid = 1'b1;
    if (expect_rsp) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
    @(posedge system_clk);
    #1;
    acc_cyc = cyc;
    check({nm, "_ready_drop"}, 64'(cmd_ready), 64'd0);
    @(negedge system_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input string nm);
    int k;
    k = 0;
    while (rsp_cnt < target && k < 2000) begin @(posedge system_clk); #2; k++; end
    if (rsp_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL %s_rsp_timeout: rsp count %0d expected %0d", nm, rsp_cnt, target);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int base;
    int k;
    // Reset values
    repeat (3) @(negedge system_clk);
    check("rst_tck", 64'(TCK), 64'd0);
    check("rst_tms", 64'(TMS), 64'd1);
    check("rst_tdi", 64'(TDI), 64'd1);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    reset_bar = 1'b1;

    // RESET: 1,1,1,1,1,0 over 6 TCK periods = 24 system cycles
    issue(OP_RESET, 0, '0, '0, 1'b1, "reset1");
    wait_rsp(1, "reset1");
    check("reset1_periods", 64'(tms_log.size()), 64'd6);
    check("reset1_tms", log_bits(1'b0, 0, 6), 64'h1F);
    check("reset1_cycles", 64'(rsp_cyc - acc_cyc), 64'd24);
    check("reset1_tap_state", 64'(tap_st), 64'd1);
    @(negedge system_clk);
    check("between_tms", 64'(TMS), 64'd0);
    check("between_tdi", 64'(TDI), 64'd1);

    // SHIFT_IR len 3, data 110, TAP shifts out 1,0,1
    issue(OP_IR, 3, 32'b110, 32'h5, 1'b1, "ir3");
    wait_rsp(2, "ir3");
    check("ir3_periods", 64'(tms_log.size()), 64'd9);
    check("ir3_tms", log_bits(1'b0, 0, 9), 64'hC3);
    check("ir3_tdi", log_bits(1'b1, 4, 3), 64'h6);
    check("ir3_tap_ir", 64'(ir), 64'h6);
    check("ir3_tap_state", 64'(tap_st), 64'd1);

    // SHIFT_DR len 1 through bypass: capture value 0 comes back
    issue(OP_DR, 1, 32'h1, 32'h0, 1'b1, "dr1");
    wait_rsp(3, "dr1");
    check("dr1_periods", 64'(tms_log.size()), 64'd6);
    check("dr1_tms", log_bits(1'b0, 0, 6), 64'h19);
    check("dr1_tap_state", 64'(tap_st), 64'd1);

    // SHIFT_DR len 0: no TCK, response in the cycle after acceptance
    issue(OP_DR, 0, 32'hFFFF_FFFF, 32'h0, 1'b1, "dr0");
    wait_rsp(4, "dr0");
    check("dr0_latency", 64'(rsp_cyc - acc_cyc), 64'd0);
    check("dr0_periods", 64'(tms_log.size()), 64'd0);

    // SHIFT_DR len 40 clamps to 32; bypass delays TDI by one bit
    issue(OP_DR, 40, 32'hDEAD_BEEF, 32'hBD5B_7DDE, 1'b1, "dr40");
    wait_rsp(5, "dr40");
    check("dr40_periods", 64'(tms_log.size()), 64'd37);
    check("dr40_tdi", log_bits(1'b1, 3, 32), 64'hDEAD_BEEF);
    check("dr40_last_shift_tms", log_bits(1'b0, 33, 4), 64'h6);

    // Reset pulsed during the 5th shift bit aborts silently
    issue(OP_DR, 8, 32'hA5, '0, 1'b0, "abort");
    k = 0;
    while (tms_log.size() < 8 && k < 500) begin @(negedge system_clk); k++; end
    check("abort_reached_bit5", 64'(tms_log.size()), 64'd8);
    base = rsp_cnt;
    #3;
    reset_bar = 1'b0;
    #1;
    check("abort_tck", 64'(TCK), 64'd0);
    check("abort_tms", 64'(TMS), 64'd1);
    check("abort_tdi", 64'(TDI), 64'd1);
    check("abort_ready", 64'(cmd_ready), 64'd1);
    repeat (3) @(negedge system_clk);
    reset_bar = 1'b1;
    repeat (20) @(negedge system_clk);
    check("abort_no_rsp", 64'(rsp_cnt), 64'(base));

    issue(OP_RESET, 0, '0, '0, 1'b1, "reset2");
    wait_rsp(base + 1, "reset2");
    check("reset2_tms", log_bits(1'b0, 0, 6), 64'h1F);
    check("reset2_tap_state", 64'(tap_st), 64'd1);

    // Two IDLE len 4 commands with cmd_valid held high
    wait_ready("idle");
    @(negedge system_clk);
    tms_log.delete();
    tdi_log.delete();
    base      = rsp_cnt;
    cmd_op    = OP_IDLE;
    cmd_len   = LEN_W'(4);
    cmd_data  = 32'h1234_5678;
    cmd_valid = 1'b1;
    exp_q.push_back('0);  name_q.push_back("idle_a");
    exp_q.push_back('0);  name_q.push_back("idle_b");
    @(posedge system_clk);
    #1;
    check("idle_a_ready_drop", 64'(cmd_ready), 64'd0);
    repeat (5) @(posedge system_clk);
    #1;
    check("idle_a_busy", 64'(cmd_ready), 64'd0);
    wait_rsp(base + 1, "idle_a");
    check("idle_a_ready_in_done", 64'(cmd_ready), 64'd0);
    check("idle_a_periods", 64'(tms_log.size()), 64'd4);
    @(posedge system_clk);
    #1;
    check("idle_ready_after_rsp", 64'(cmd_ready), 64'd1);
    @(posedge system_clk);
    #1;
    check("idle_b_accepted", 64'(cmd_ready), 64'd0);
    @(negedge system_clk);
    cmd_valid = 1'b0;
    wait_rsp(base + 2, "idle_b");
    check("idle_periods", 64'(tms_log.size()), 64'd8);
    check("idle_tms", log_bits(1'b0, 0, 8), 64'h00);
    check("idle_tdi", log_bits(1'b1, 0, 8), 64'hFF);

    repeat (10) @(negedge system_clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_tap_master.md
Name: jtag_tap_master

Overview:
- Command-driven JTAG host engine. It sits directly upstream of the TAP controller and drives that controller's TMS/TCK/TDI inputs.
- It converts IR-scan, DR-scan, reset and idle commands from on-chip logic into TAP-legal TMS/TDI sequences on a divided TCK.
- It collects the TDO bits shifted out and returns them as one response word.

Parameters:
- DATA_W, 32, maximum scan length in bits; width of cmd_data and rsp_data.
- LEN_W, 6, width of cmd_len; must satisfy 2**LEN_W > DATA_W.
- TCK_DIV, 4, system_clk cycles per TCK half-period; legal values are 1 or more.

Ports:
- system_clk  in  1  system clock; all logic is on its rising edge.
- reset_bar  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block is idle and can accept a command.
- cmd_op  in  2  00 RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 IDLE.
- cmd_len  in  LEN_W  bit count for shifts, TCK count for IDLE.
- cmd_data  in  DATA_W  TDI bits, shifted LSB first.
- rsp_valid  out  1  one-cycle pulse when a command completes.
- rsp_data  out  DATA_W  captured TDO bits, right-aligned.
- TCK  out  1  test clock to the TAP.
- TMS  out  1  test mode select.
- TDI  out  1  test data in.
- TDO  in  1  test data out from the TAP.

Behaviour:
- Reset (async, reset_bar=0) forces these values immediately: TCK=0, TMS=1, TDI=1, cmd_ready=1, rsp_valid=0, rsp_data=0, FSM=S_IDLE, divider=0.
  - Asserting reset mid-command aborts the command with no rsp_valid.
- TCK generation:
  - A divider runs 0..2*TCK_DIV-1 only outside S_IDLE and S_DONE.
  - TCK=1 when the divider is at TCK_DIV or above, else 0. TCK idles low.
  - TMS/TDI update on the system edge where the divider wraps to 0 (the TCK falling edge).
  - TDO is sampled on the system edge where the divider reaches TCK_DIV (the TCK rising edge).
- Handshake:
  - A command is accepted when cmd_valid and cmd_ready are both 1.
  - cmd_ready drops the next cycle and stays 0 until the cycle after rsp_valid.
  - cmd_op, cmd_len and cmd_data are latched at acceptance.
  - The first TMS/TDI value is driven 1 cycle after acceptance.
- Length rules:
  - cmd_len greater than DATA_W is clamped to DATA_W.
  - cmd_len=0 (any op except RESET) produces no TCK edges; rsp_valid fires 1 cycle after acceptance with rsp_data=0.
- FSM: S_IDLE -> S_PRE -> S_SHIFT -> S_POST -> S_DONE -> S_IDLE. Each TMS bit in PRE, SHIFT and POST occupies one full TCK period.
  - RESET: PRE drives TMS = 1,1,1,1,1 then 0, which leaves the TAP in Run-Idle. SHIFT and POST are skipped. TDI=1.
  - SHIFT_IR: PRE drives TMS = 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
  - SHIFT_DR: PRE drives TMS = 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - Both shifts, SHIFT phase: cmd_len TCK periods with TDI = data[i], LSB first. TMS=0 except on the last bit, where TMS=1 (Exit1). TDO is sampled on each rising edge and shifted in at the MSB of a cmd_len-wide window, so the first TDO bit ends at rsp_data[0].
  - Both shifts, POST: drives TMS = 1 (Update) then 0 (Run-Idle). TDI=1.
  - IDLE: SHIFT phase runs cmd_len TCK periods with TMS=0, TDI=1. PRE and POST are skipped.
  - S_DONE: TCK low, rsp_valid=1 for one cycle, rsp_data valid and held until the next acceptance. Then return to S_IDLE.
- Bits of rsp_data above cmd_len are 0. rsp_data is 0 for RESET and IDLE.
- Between commands: TMS=0, TDI=1, TCK=0, so the TAP stays in Run-Idle.
- The master does not check TAP state; shift commands assume the TAP is in Run-Idle. Software issues RESET first.

Optional Feature:
- Macro JTAG_TAP_MASTER_STATE_TRACK_EN.
- Defined:
  - Adds output tap_state[3:0], a shadow of the TAP state using the TAP controller's encoding (Reset=0 … Update_IR=15).
  - Resets to 0 on reset_bar and advances from the current TMS on each TCK rising edge.
  - Adds output tap_state_err, which pulses 1 cycle when a SHIFT_IR or SHIFT_DR is accepted while tap_state is not 1 (Run-Idle). The command still executes.
- Not defined: both ports and the shadow logic are absent.

Test Plan:
- TCK_DIV=2, RESET -> TMS 1,1,1,1,1,0 over 6 TCK periods (24 system cycles); rsp_valid pulses once; rsp_data=0; a TAP model reports Run-Idle.
- SHIFT_IR, len=3, data=3'b110, model TDO 1,0,1 -> TMS 1,1,0,0,0,0,1,1,0; TDI during shift 0,1,1; rsp_data=0x5; TAP IR=3'b110.
- SHIFT_DR, len=1 (bypass selected), data=1 -> TMS 1,0,0,1,1,0; the single shift bit carries TMS=1; rsp_data[0] equals the bypass capture value 0.
- SHIFT_DR with len=0 -> no TCK edge and rsp_valid 1 cycle after acceptance, rsp_data=0. SHIFT_DR with len=40 -> exactly 32 shift periods.
- reset_bar pulsed during the 5th shift bit -> TCK=0, TMS=1, TDI=1, cmd_ready=1 immediately; no rsp_valid; the next RESET command completes normally.
- cmd_valid held high across two IDLE len=4 commands -> cmd_ready=0 while busy; the second command is accepted the cycle after the first rsp_valid; 4 TCK periods with TMS=0 each.
